// File: rtl/ysyx_22040386_mem_arbiter.sv
// Shares one 64-bit memory port between IFU fetches and LSU loads/stores, one transaction in flight.
// Latency: grant at N, mem request from N+1, response pulse earliest at N+2 (same cycle as mem_rsp_valid).
// Backpressure: requesters wait on ready (only high in IDLE); memory backpressure holds the request in REQ.
module ysyx_22040386_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_ARB_clk,
  input  logic        i_ARB_rst_n,
  input  logic        i_ARB_if_valid,
  input  logic [63:0] i_ARB_if_addr,
  output logic        o_ARB_if_ready,
  output logic        o_ARB_if_rsp_valid,
  output logic [63:0] o_ARB_if_rdata,
  input  logic        i_ARB_ls_valid,
  input  logic        i_ARB_ls_wen,
  input  logic [63:0] i_ARB_ls_addr,
  input  logic [63:0] i_ARB_ls_wdata,
  input  logic [7:0]  i_ARB_ls_wmask,
  output logic        o_ARB_ls_ready,
  output logic        o_ARB_ls_rsp_valid,
  output logic [63:0] o_ARB_ls_rdata,
  output logic        o_ARB_mem_req_valid,
  input  logic        i_ARB_mem_req_ready,
  output logic        o_ARB_mem_wen,
  output logic [63:0] o_ARB_mem_addr,
  output logic [63:0] o_ARB_mem_wdata,
  output logic [7:0]  o_ARB_mem_wmask,
  input  logic        i_ARB_mem_rsp_valid,
  input  logic [63:0] i_ARB_mem_rdata,
  output logic        o_ARB_busy
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} owner_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  owner_t      owner;
  logic [3:0]  starve;
  logic        wen_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [63:0] if_rdata_q;
  logic [63:0] ls_rdata_q;

  logic idle;
  logic force_if;
  logic grant_ls;
  logic grant_if;
  logic rsp_fire;

  // Readies are gated by reset so every output is low while reset is held.
  assign idle     = (state == IDLE) && i_ARB_rst_n;
  assign force_if = i_ARB_if_valid && (starve == LIMIT);
  assign grant_ls = idle && i_ARB_ls_valid && !force_if;
  assign grant_if = idle && i_ARB_if_valid && !grant_ls;
  assign rsp_fire = (state == RESP) && i_ARB_mem_rsp_valid;

  assign o_ARB_if_ready     = grant_if;
  assign o_ARB_ls_ready     = grant_ls;
  assign o_ARB_if_rsp_valid = rsp_fire && (owner == OWN_IF);
  assign o_ARB_ls_rsp_valid = rsp_fire && (owner == OWN_LS);

  // Read data passes straight through on the response cycle, then holds.
  assign o_ARB_if_rdata = o_ARB_if_rsp_valid ? i_ARB_mem_rdata : if_rdata_q;
  assign o_ARB_ls_rdata = o_ARB_ls_rsp_valid ? (wen_q ? 64'h0 : i_ARB_mem_rdata) : ls_rdata_q;

  assign o_ARB_mem_req_valid = (state == REQ);
  assign o_ARB_mem_wen       = wen_q;
  assign o_ARB_mem_addr      = addr_q;
  assign o_ARB_mem_wdata     = wdata_q;
  assign o_ARB_mem_wmask     = wmask_q;
  assign o_ARB_busy          = (state != IDLE);

  always_ff @(posedge i_ARB_clk or negedge i_ARB_rst_n) begin
    if (!i_ARB_rst_n) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve     <= 4'd0;
      wen_q      <= 1'b0;
      addr_q     <= 64'h0;
      wdata_q    <= 64'h0;
      wmask_q    <= 8'h00;
      if_rdata_q <= 64'h0;
      ls_rdata_q <= 64'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ls) begin
            owner   <= OWN_LS;
            wen_q   <= i_ARB_ls_wen;
            addr_q  <= i_ARB_ls_addr;
            wdata_q <= i_ARB_ls_wdata;
            wmask_q <= i_ARB_ls_wen ? i_ARB_ls_wmask : 8'h00;
            state   <= REQ;
            // Only count LSU wins that actually made the IFU wait.
            if (i_ARB_if_valid)
              starve <= (starve >= LIMIT) ? LIMIT : starve + 4'd1;
            else
              starve <= 4'd0;
          end else if (grant_if) begin
            owner   <= OWN_IF;
            wen_q   <= 1'b0;
            addr_q  <= i_ARB_if_addr;
            wdata_q <= 64'h0;
            wmask_q <= 8'h00;
            starve  <= 4'd0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (i_ARB_mem_req_ready)
            state <= RESP;
        end
        RESP: begin
          if (i_ARB_mem_rsp_valid) begin
            if (owner == OWN_IF)
              if_rdata_q <= i_ARB_mem_rdata;
            if (owner == OWN_LS)
              ls_rdata_q <= wen_q ? 64'h0 : i_ARB_mem_rdata;
            owner <= OWN_NONE;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// Self-checking bench: vector table of single transactions plus hand sequences for starvation, withdraw and reset.
module tb_ysyx_22040386_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [63:0] if_addr;
  logic        if_ready;
  logic        if_rsp_valid;
  logic [63:0] if_rdata;
  logic        ls_valid;
  logic        ls_wen;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_ready;
  logic        ls_rsp_valid;
  logic [63:0] ls_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        busy;

  ysyx_22040386_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_ARB_clk           (clk),
    .i_ARB_rst_n         (rst_n),
    .i_ARB_if_valid      (if_valid),
    .i_ARB_if_addr       (if_addr),
    .o_ARB_if_ready      (if_ready),
    .o_ARB_if_rsp_valid  (if_rsp_valid),
    .o_ARB_if_rdata      (if_rdata),
    .i_ARB_ls_valid      (ls_valid),
    .i_ARB_ls_wen        (ls_wen),
    .i_ARB_ls_addr       (ls_addr),
    .i_ARB_ls_wdata      (ls_wdata),
    .i_ARB_ls_wmask      (ls_wmask),
    .o_ARB_ls_ready      (ls_ready),
    .o_ARB_ls_rsp_valid  (ls_rsp_valid),
    .o_ARB_ls_rdata      (ls_rdata),
    .o_ARB_mem_req_valid (mem_req_valid),
    .i_ARB_mem_req_ready (mem_req_ready),
    .o_ARB_mem_wen       (mem_wen),
    .o_ARB_mem_addr      (mem_addr),
    .o_ARB_mem_wdata     (mem_wdata),
    .o_ARB_mem_wmask     (mem_wmask),
    .i_ARB_mem_rsp_valid (mem_rsp_valid),
    .i_ARB_mem_rdata     (mem_rdata),
    .o_ARB_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h1234;
    return {a[31:0], ~a[31:0]};
  endfunction

  // Memory model: configurable ready delay, response delay and junk responses during REQ.
  int m_rdy = 0;
  int m_rsp = 1;
  bit m_spur = 0;

  initial begin
    int ph;
    int cnt;
    logic [63:0] a;
    ph = 0; cnt = 0; a = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        ph = 0;
        mem_req_ready = 1'b0;
      end else begin
        if (ph == 1 && mem_req_ready) begin
          mem_req_ready = 1'b0;
          ph = 2;
          cnt = m_rsp;
        end
        if (ph == 0 && mem_req_valid) begin
          ph = 1;
          cnt = m_rdy;
          a = mem_addr;
        end
        if (ph == 1) begin
          if (cnt == 0) mem_req_ready = 1'b1;
          else begin
            cnt--;
            if (m_spur) begin
              mem_rsp_valid = 1'b1;
              mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end
          end
        end else if (ph == 2) begin
          cnt--;
          if (cnt <= 0) begin
            mem_rsp_valid = 1'b1;
            mem_rdata = mem_fn(a);
            ph = 0;
          end
        end
      end
    end
  end

  // Scoreboard: expected responses pushed at acceptance, popped on rsp pulses.
  typedef struct {
    bit          is_ls;
    logic [63:0] rdata;
  } exp_t;

  exp_t        sb[$];
  byte         grant_log[$];
  logic        exp_wen;
  logic [63:0] exp_addr;
  logic [63:0] exp_wdata;
  logic [7:0]  exp_wmask;

  initial begin
    exp_t e;
    exp_wen = 0; exp_addr = '0; exp_wdata = '0; exp_wmask = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("ready_while_busy", {63'h0, busy & (if_ready | ls_ready)}, 64'h0);
        if (if_valid && if_ready) begin
          sb.push_back('{1'b0, mem_fn(if_addr)});
          grant_log.push_back("I");
          exp_wen = 1'b0; exp_addr = if_addr; exp_wdata = '0; exp_wmask = 8'h00;
        end
        if (ls_valid && ls_ready) begin
          sb.push_back('{1'b1, ls_wen ? 64'h0 : mem_fn(ls_addr)});
          grant_log.push_back("L");
          exp_wen = ls_wen; exp_addr = ls_addr; exp_wdata = ls_wdata;
          exp_wmask = ls_wen ? ls_wmask : 8'h00;
        end
        if (mem_req_valid) begin
          chk("mem_wen", {63'h0, mem_wen}, {63'h0, exp_wen});
          chk("mem_addr", mem_addr, exp_addr);
          chk("mem_wmask", {56'h0, mem_wmask}, {56'h0, exp_wmask});
          if (exp_wen) chk("mem_wdata", mem_wdata, exp_wdata);
        end
        if (if_rsp_valid || ls_rsp_valid) begin
          rsp_cnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual=if%0b/ls%0b required=no response (cycle %0d)",
                     if_rsp_valid, ls_rsp_valid, cyc);
          end else begin
            e = sb.pop_front();
            chk("rsp_owner", {62'h0, if_rsp_valid, ls_rsp_valid}, e.is_ls ? 64'h1 : 64'h2);
            chk("rsp_rdata", e.is_ls ? ls_rdata : if_rdata, e.rdata);
          end
        end
      end
    end
  end

  typedef struct {
    bit          is_ls;
    bit          wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          rdy;
    int          rsp;
    bit          spur;
    logic [63:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int t0;
    int c0;
    bit got;
    logic [63:0] rd;
    m_rdy = v.rdy; m_rsp = v.rsp; m_spur = v.spur;
    c0 = rsp_cnt;
    @(posedge clk); #1;
    if (v.is_ls) begin
      ls_valid = 1; ls_wen = v.wen; ls_addr = v.addr; ls_wdata = v.wdata; ls_wmask = v.wmask;
    end else begin
      if_valid = 1; if_addr = v.addr;
    end
    got = 0; t0 = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (v.is_ls ? ls_ready : if_ready) begin got = 1; t0 = cyc; end
    end
    chk($sformatf("v%0d_accept", idx), {63'h0, got}, 64'h1);
    @(posedge clk); #1;
    if_valid = 0; ls_valid = 0;
    got = 0; rd = '0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (v.is_ls ? ls_rsp_valid : if_rsp_valid) begin
        got = 1;
        rd = v.is_ls ? ls_rdata : if_rdata;
        chk($sformatf("v%0d_latency", idx), 64'(cyc - t0), 64'(v.exp_lat));
      end
    end
    chk($sformatf("v%0d_rsp_seen", idx), {63'h0, got}, 64'h1);
    chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    @(negedge clk);
    chk($sformatf("v%0d_busy_after", idx), {63'h0, busy}, 64'h0);
    chk($sformatf("v%0d_rdata_hold", idx), v.is_ls ? ls_rdata : if_rdata, v.exp_rdata);
    chk($sformatf("v%0d_rsp_once", idx), 64'(rsp_cnt - c0), 64'h1);
    m_spur = 0;
  endtask

  task automatic wait_ls_ready();
    bit got;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (ls_ready) got = 1;
    end
    chk("ls_accept", {63'h0, got}, 64'h1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    chk("return_idle", {63'h0, done}, 64'h1);
  endtask

  vec_t vecs[5];

  initial begin
    vec_t v;
    int   g0;
    int   c0;
    byte  exp_g;
    bit   done;

    vecs[0] = '{0, 0, 64'h8000_0000, 64'h0, 8'h00, 0, 1, 0, 64'h1234, 2};
    vecs[1] = '{1, 1, 64'h8000_0010, 64'hDEAD_BEEF, 8'h0F, 3, 1, 0, 64'h0, 5};
    vecs[2] = '{1, 0, 64'h8000_0008, 64'h5555, 8'hFF, 1, 2, 0, 64'h8000_0008_7FFF_FFF7, 4};
    vecs[3] = '{0, 0, 64'h8000_0104, 64'h0, 8'h00, 2, 1, 1, 64'h8000_0104_7FFF_FEFB, 4};
    vecs[4] = '{1, 1, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hF0, 0, 1, 0, 64'h0, 2};

    rst_n = 0;
    if_valid = 0; if_addr = '0;
    ls_valid = 0; ls_wen = 0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
    #1;
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_mem_req_valid", {63'h0, mem_req_valid}, 64'h0);
    chk("reset_mem_addr", mem_addr, 64'h0);
    chk("reset_if_rdata", if_rdata, 64'h0);
    chk("reset_ls_rdata", ls_rdata, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Both requesters valid continuously: four LSU wins, then IFU, and the count restarts.
    m_rdy = 0; m_rsp = 1;
    grant_log.delete();
    @(posedge clk); #1;
    if_valid = 1; if_addr = 64'h8000_0200;
    ls_valid = 1; ls_wen = 0; ls_addr = 64'h8000_0300;
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk);
      if (grant_log.size() >= 12) done = 1;
    end
    #1;
    if_valid = 0; ls_valid = 0;
    chk("starve_grants_seen", {63'h0, done}, 64'h1);
    wait_idle();
    for (int i = 0; i < 12 && i < grant_log.size(); i++) begin
      exp_g = ((i % 5) == 4) ? 8'd73 : 8'd76;
      chk($sformatf("grant_order_%0d", i), 64'(grant_log[i]), 64'(exp_g));
    end

    // IFU valid raised then withdrawn while an LSU transaction is in flight.
    m_rdy = 3; m_rsp = 1;
    g0 = grant_log.size();
    @(posedge clk); #1;
    ls_valid = 1; ls_wen = 0; ls_addr = 64'h8000_0040;
    wait_ls_ready();
    @(posedge clk); #1;
    ls_valid = 0;
    if_valid = 1; if_addr = 64'h8000_0044;
    repeat (2) @(posedge clk);
    #1 if_valid = 0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("withdraw_grants", 64'(grant_log.size() - g0), 64'h1);
    chk("withdraw_no_mem_req", {63'h0, mem_req_valid}, 64'h0);
    v = '{0, 0, 64'h8000_0044, 64'h0, 8'h00, 0, 1, 0, 64'h8000_0044_7FFF_FFBB, 2};
    run_vec(v, 5);

    // Asynchronous reset while an LSU read waits in RESP.
    m_rdy = 0; m_rsp = 6;
    @(posedge clk); #1;
    ls_valid = 1; ls_wen = 0; ls_addr = 64'h8000_0080;
    wait_ls_ready();
    @(posedge clk); #1;
    ls_valid = 0;
    @(posedge clk); #3;
    chk("pre_reset_busy", {63'h0, busy}, 64'h1);
    chk("pre_reset_in_resp", {63'h0, mem_req_valid}, 64'h0);
    rst_n = 0;
    #1;
    sb.delete();
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_mem_addr", mem_addr, 64'h0);
    chk("arst_ls_rsp_valid", {63'h0, ls_rsp_valid}, 64'h0);
    chk("arst_if_rdata", if_rdata, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    c0 = rsp_cnt;
    repeat (10) @(negedge clk);
    chk("arst_no_late_rsp", 64'(rsp_cnt - c0), 64'h0);
    chk("arst_idle_after", {63'h0, busy}, 64'h0);
    m_rsp = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22040386_mem_arbiter.md
Name: ysyx_22040386_mem_arbiter

Overview:
- Two-requester arbiter sharing one 64-bit data-memory port between instruction fetch (IFU, read-only) and load/store (LSU, read or byte-masked write).
- Sits between the IF/MEM stages and the memory/DPI bridge.
- Handles one outstanding transaction at a time. Each request is latched at acceptance, issued on the memory port, and the response is routed back to the owning requester.
- LSU has fixed priority, with a starvation guard for IFU.

Parameters:
- STARVE_LIMIT, 4: number of consecutive LSU grants taken while IFU is waiting before IFU is forced to win the next arbitration (range 1..15).

Ports:
- i_ARB_clk  in  1  clock, all state on rising edge
- i_ARB_rst_n  in  1  asynchronous active-low reset
- i_ARB_if_valid  in  1  IFU read request
- i_ARB_if_addr  in  64  IFU fetch address
- o_ARB_if_ready  out  1  IFU request accepted this cycle
- o_ARB_if_rsp_valid  out  1  IFU read data valid (1-cycle pulse)
- o_ARB_if_rdata  out  64  IFU read data
- i_ARB_ls_valid  in  1  LSU request
- i_ARB_ls_wen  in  1  1 = write, 0 = read
- i_ARB_ls_addr  in  64  LSU address
- i_ARB_ls_wdata  in  64  LSU write data
- i_ARB_ls_wmask  in  8  LSU byte write mask
- o_ARB_ls_ready  out  1  LSU request accepted this cycle
- o_ARB_ls_rsp_valid  out  1  LSU completion / read data valid (1-cycle pulse)
- o_ARB_ls_rdata  out  64  LSU read data; 0 for writes
- o_ARB_mem_req_valid  out  1  memory request valid
- i_ARB_mem_req_ready  in  1  memory accepts request
- o_ARB_mem_wen  out  1  memory write enable
- o_ARB_mem_addr  out  64  memory address
- o_ARB_mem_wdata  out  64  memory write data
- o_ARB_mem_wmask  out  8  memory byte mask; 8'h00 on reads
- i_ARB_mem_rsp_valid  in  1  memory response (reads and writes both respond)
- i_ARB_mem_rdata  in  64  memory read data
- o_ARB_busy  out  1  state != IDLE

Behaviour:
- Reset state:
  - State = IDLE; owner = none; starve counter = 0.
  - All outputs 0, including latched addr/wdata/wmask.
  - Reset is asynchronous and takes effect mid-transaction: any in-flight request is dropped and no rsp_valid is produced for it.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Arbitration is combinational.
  - If ls_valid && !(if_valid && starve == STARVE_LIMIT): grant LSU.
  - Else if if_valid: grant IFU.
  - The granted ready output is high in the same cycle; the other ready is 0.
  - On grant, latch addr/wen/wdata/wmask and the owner, then go to REQ.
  - An IFU grant latches wen=0 and wmask=0.
- Starve counter:
  - On an LSU grant while if_valid=1: increment, saturating at STARVE_LIMIT.
  - On an IFU grant, or when if_valid=0 at an LSU grant: clear to 0.
- REQ:
  - mem_req_valid=1 with the latched fields stable.
  - When mem_req_ready=1: go to RESP next cycle. mem_req_valid drops that same edge.
  - Any mem_rsp_valid seen in REQ is ignored.
- RESP:
  - Wait for mem_rsp_valid.
  - On mem_rsp_valid, in the same cycle, pulse the owner's rsp_valid with rdata = mem_rdata. LSU writes return rdata = 0.
  - Next state is IDLE.
  - rdata outputs hold their last value when rsp_valid=0.
- Latency: accept at cycle N; mem_req_valid from N+1; earliest rsp_valid at N+2 (memory ready at N+1, response at N+2).
- Back-to-back: no new grant in the response cycle. The next grant is at the earliest in the cycle after the response. Readies are never high outside IDLE.
- Simultaneous if_valid and ls_valid in IDLE: LSU wins unless the starve counter is saturated.
- Requesters hold valid and fields until ready. A withdrawn valid before ready is legal, and nothing is latched.
- Unknown owner in RESP cannot occur; if owner = none, the response is discarded and the FSM returns to IDLE.

Test Plan:
- IFU-only read, addr 0x8000_0000, memory ready immediately, rdata 0x1234 one cycle later -> if_ready at N, mem_req_valid at N+1 with wen=0 / wmask=0, if_rsp_valid pulse at N+2 with rdata 0x1234, busy returns to 0 at N+3.
- LSU write addr 0x8000_0010, wdata 0xDEAD_BEEF, wmask 8'h0F, mem_req_ready delayed 3 cycles -> fields held stable all 3 cycles; ls_rsp_valid on the memory response with ls_rdata = 0.
- Both valid continuously, STARVE_LIMIT = 4, single-cycle memory -> grant order LSU, LSU, LSU, LSU, IFU, LSU…; counter clears after the IFU grant.
- mem_rsp_valid asserted during REQ before mem_req_ready -> ignored; only the response in RESP pulses rsp_valid, exactly once.
- Reset asserted asynchronously while in RESP with an LSU read outstanding -> outputs 0 immediately, state IDLE, no ls_rsp_valid after reset release.
- IFU valid withdrawn while an LSU transaction is busy, then reasserted -> if_ready only in IDLE; no stale IFU transaction is issued.
